// File: rtl/spi_master_controller_if.sv
// Host-side handshake/config and SPI pin bundle for spi_master_controller.
interface spi_master_controller_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int BAUD_DIV_WIDTH = 8
);
  logic                      start_i;
  logic [DATA_WIDTH-1:0]     tx_data_i;
  logic                      cpol_i;
  logic                      cpha_i;
  logic                      lsb_first_i;
  logic [BAUD_DIV_WIDTH-1:0] baud_div_i;
  logic                      miso0_i;
  logic                      sclk_o;
  logic                      cs_n_o;
  logic                      mosi0_o;
  logic                      ready_o;
  logic                      done_o;
  logic [DATA_WIDTH-1:0]     rx_data_o;

  modport master (
    input  start_i, tx_data_i, cpol_i, cpha_i, lsb_first_i, baud_div_i, miso0_i,
    output sclk_o, cs_n_o, mosi0_o, ready_o, done_o, rx_data_o
  );

  modport slave (
    output start_i, tx_data_i, cpol_i, cpha_i, lsb_first_i, baud_div_i, miso0_i,
    input  sclk_o, cs_n_o, mosi0_o, ready_o, done_o, rx_data_o
  );
endinterface

// File: rtl/spi_master_controller.sv
// Single-word SPI master with programmable CPOL/CPHA, bit order and sclk divider.
// Define SPI_MASTER_CTRL_LOOPBACK_EN to receive the internal mosi stream instead of miso0_i.
//
// state | meaning
// IDLE  | ready, config latched on start_i
// SETUP | cs_n low, sclk at cpol, one half-period
// SHIFT | 2*DATA_WIDTH sclk toggles, one per half-period
// HOLD  | sclk back at cpol, one half-period before release
// DONE  | one-cycle done_o pulse, rx_data_o updated
module spi_master_controller #(
  parameter int DATA_WIDTH     = 8,
  parameter int BAUD_DIV_WIDTH = 8
) (
  input  logic                    pclk,
  input  logic                    areset,
  spi_master_controller_if.master bus
);
  localparam int NTOG = 2 * DATA_WIDTH;
  localparam int TW   = $clog2(NTOG + 1);
  localparam int IW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t                    state, state_nxt;
  logic [DATA_WIDTH-1:0]     tx_l, rx_sh, rx_q;
  logic                      cpol_l, cpha_l, lsb_l;
  logic [BAUD_DIV_WIDTH-1:0] bd_l, cnt;
  logic [TW-1:0]             tcnt, tcnt_nxt;
  logic                      sclk_q, mosi_q;
  logic                      tc, accept, toggle, last_tog;
  logic                      sample_en, update_en, rx_bit, tx_bit, first_bit;
  logic [IW-1:0]             bit_idx;

  assign tc        = (cnt == '0);
  assign accept    = (state == IDLE) && bus.start_i;
  assign tcnt_nxt  = tcnt + TW'(1);
  assign toggle    = tc && ((state == SETUP) || (state == SHIFT));
  assign last_tog  = tc && (state == SHIFT) && (tcnt_nxt == TW'(NTOG));
  // Toggle parity against cpha picks the sampling edge; the other parity launches mosi.
  assign sample_en = toggle && (tcnt_nxt[0] != cpha_l);
  assign update_en = toggle && (tcnt_nxt[0] == cpha_l) && !last_tog;
  assign bit_idx   = tcnt_nxt[IW:1];
  assign tx_bit    = lsb_l ? tx_l[bit_idx] : tx_l[IW'(DATA_WIDTH - 1) - bit_idx];
  assign first_bit = bus.lsb_first_i ? bus.tx_data_i[0] : bus.tx_data_i[DATA_WIDTH-1];

`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
  assign rx_bit = mosi_q;
`else
  assign rx_bit = bus.miso0_i;
`endif

  always_ff @(posedge pclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.ready_o = 1'b0;
    bus.done_o  = 1'b0;
    bus.cs_n_o  = 1'b1;
    case (state)
      IDLE: begin
        bus.ready_o = 1'b1;
        if (bus.start_i) state_nxt = SETUP;
      end
      SETUP: begin
        bus.cs_n_o = 1'b0;
        if (tc) state_nxt = SHIFT;
      end
      SHIFT: begin
        bus.cs_n_o = 1'b0;
        if (last_tog) state_nxt = HOLD;
      end
      HOLD: begin
        bus.cs_n_o = 1'b0;
        if (tc) state_nxt = DONE;
      end
      DONE: begin
        bus.done_o = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (areset) begin
      tx_l   <= '0;
      rx_sh  <= '0;
      rx_q   <= '0;
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      lsb_l  <= 1'b0;
      bd_l   <= '0;
      cnt    <= '0;
      tcnt   <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      if (accept) begin
        tx_l   <= bus.tx_data_i;
        cpol_l <= bus.cpol_i;
        cpha_l <= bus.cpha_i;
        lsb_l  <= bus.lsb_first_i;
        bd_l   <= bus.baud_div_i;
        cnt    <= bus.baud_div_i;
        tcnt   <= '0;
        sclk_q <= bus.cpol_i;
        mosi_q <= first_bit;
      end else if ((state == SETUP) || (state == SHIFT) || (state == HOLD)) begin
        cnt <= tc ? bd_l : cnt - BAUD_DIV_WIDTH'(1);
      end
      if (toggle) begin
        sclk_q <= ~sclk_q;
        tcnt   <= tcnt_nxt;
      end
      if (update_en) mosi_q <= tx_bit;
      if (sample_en) begin
        if (lsb_l) rx_sh <= {rx_bit, rx_sh[DATA_WIDTH-1:1]};
        else       rx_sh <= {rx_sh[DATA_WIDTH-2:0], rx_bit};
      end
      if ((state == HOLD) && tc) rx_q <= rx_sh;
    end
  end

  assign bus.sclk_o    = sclk_q;
  assign bus.mosi0_o   = mosi_q;
  assign bus.rx_data_o = rx_q;
endmodule

// File: tb/tb_spi_master_controller.sv
// Randomized bench for spi_master_controller: per-cycle timeline model plus directed literal checks.
module tb_spi_master_controller;
  localparam int DW = 8;
  localparam int BW = 8;

`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic pclk = 1'b0;
  logic areset;
  always #5 pclk = ~pclk;

  spi_master_controller_if #(.DATA_WIDTH(DW), .BAUD_DIV_WIDTH(BW)) bus();
  spi_master_controller #(.DATA_WIDTH(DW), .BAUD_DIV_WIDTH(BW)) dut (
    .pclk(pclk), .areset(areset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int t_cur = -2;

  // transfer model: timeline expressed as cycles since the accepting edge
  logic          m_cpol, m_cpha, m_lsb;
  int            m_half = 1;
  logic [DW-1:0] m_tx, m_sw, m_rx_old, m_rx_new;
  logic          m_idle_cpol;
  logic [DW-1:0] m_idle_rx;

  int            mon_toggles, mon_rises, mon_done, mon_setup;
  logic [DW-1:0] mon_cap;
  logic          prev_sclk = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s t=%0d got=%0h expected=%0h", nm, t_cur, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic bit_of(input logic [DW-1:0] w, input int i, input logic lsb);
    logic [DW-1:0] v;
    v = w;
    return lsb ? v[i] : v[DW-1-i];
  endfunction

  function automatic int tdone();
    return (2 * DW + 1) * m_half;
  endfunction

  function automatic int ntog(input int t);
    if (t < m_half) return 0;
    return imin(2 * DW, t / m_half);
  endfunction

  function automatic logic miso_for(input int t);
    int n, i;
    n = ntog(t);
    i = m_cpha ? (n >> 1) : ((n + 1) >> 1);
    return bit_of(m_sw, imin(i, DW - 1), m_lsb);
  endfunction

  always @(negedge pclk) begin : cmp
    int n;
    if (t_cur == 0) begin
      mon_toggles = 0; mon_rises = 0; mon_done = 0; mon_setup = 0; mon_cap = '0;
    end else if (t_cur > 0 && bus.sclk_o != prev_sclk) begin
      mon_toggles++;
      if (bus.sclk_o) begin
        mon_rises++;
        mon_cap = {mon_cap[DW-2:0], bus.mosi0_o};
      end
    end
    if (t_cur >= 0) begin
      if (!bus.cs_n_o && mon_toggles == 0) mon_setup++;
      if (bus.done_o) mon_done++;
    end
    prev_sclk = bus.sclk_o;

    if (t_cur >= 0) begin
      n = ntog(t_cur);
      if (t_cur < tdone()) begin
        check("xfer_cs_n", bus.cs_n_o, 0);
        check("xfer_ready", bus.ready_o, 0);
        check("xfer_done", bus.done_o, 0);
        check("xfer_sclk", bus.sclk_o, m_cpol ^ n[0]);
        check("xfer_rx_hold", bus.rx_data_o, m_rx_old);
        if (!m_cpha)
          check("xfer_mosi", bus.mosi0_o, bit_of(m_tx, imin(n >> 1, DW - 1), m_lsb));
        else if (n >= 1)
          check("xfer_mosi", bus.mosi0_o, bit_of(m_tx, imin((n - 1) >> 1, DW - 1), m_lsb));
      end else begin
        check("done_cs_n", bus.cs_n_o, 1);
        check("done_ready", bus.ready_o, 0);
        check("done_pulse", bus.done_o, 1);
        check("done_sclk", bus.sclk_o, m_cpol);
        check("done_rx", bus.rx_data_o, m_rx_new);
      end
    end else if (t_cur == -1) begin
      check("idle_ready", bus.ready_o, 1);
      check("idle_cs_n", bus.cs_n_o, 1);
      check("idle_done", bus.done_o, 0);
      check("idle_sclk", bus.sclk_o, m_idle_cpol);
      check("idle_rx", bus.rx_data_o, m_idle_rx);
    end
  end

  task automatic scramble();
    bus.tx_data_i   = DW'($urandom);
    bus.cpol_i      = 1'($urandom);
    bus.cpha_i      = 1'($urandom);
    bus.lsb_first_i = 1'($urandom);
    bus.baud_div_i  = BW'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
      bus.start_i = 1'b0;
      bus.miso0_i = 1'b0;
      scramble();
    end
  endtask

  // Called in an IDLE cycle; returns in the IDLE cycle that follows DONE (or the reset).
  task automatic run_xfer(input logic cpol, input logic cpha, input logic lsb, input int bd,
                          input logic [DW-1:0] tx, input logic [DW-1:0] sw, input int abort_at);
    bit aborted;
    aborted = 1'b0;
    bus.start_i     = 1'b1;
    bus.cpol_i      = cpol;
    bus.cpha_i      = cpha;
    bus.lsb_first_i = lsb;
    bus.baud_div_i  = BW'(bd);
    bus.tx_data_i   = tx;
    m_cpol = cpol; m_cpha = cpha; m_lsb = lsb; m_half = bd + 1;
    m_tx = tx; m_sw = sw; m_rx_old = m_idle_rx;
    m_rx_new = LB ? tx : sw;
    for (int t = 0; t <= tdone(); t++) begin
      @(posedge pclk); #1;
      t_cur = t;
      bus.miso0_i = (t < tdone()) ? miso_for(t) : 1'($urandom);
      scramble();
      bus.start_i = 1'b1;
      if (t == abort_at) begin
        areset = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    @(posedge pclk); #1;
    if (aborted) begin
      areset = 1'b0;
      m_idle_cpol = 1'b0;
      m_idle_rx = '0;
    end else begin
      m_idle_cpol = m_cpol;
      m_idle_rx = m_rx_new;
    end
    t_cur = -1;
    bus.start_i = 1'b0;
    bus.miso0_i = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    bus.start_i = 1'b0;
    bus.miso0_i = 1'b0;
    bus.tx_data_i = '0;
    bus.cpol_i = 1'b1;
    bus.cpha_i = 1'b0;
    bus.lsb_first_i = 1'b0;
    bus.baud_div_i = '0;
    m_idle_cpol = 1'b0;
    m_idle_rx = '0;
    repeat (3) @(posedge pclk);
    #1;
    areset = 1'b0;
    t_cur = -1;
    @(negedge pclk);
    check("rst_sclk", bus.sclk_o, 0);
    check("rst_cs_n", bus.cs_n_o, 1);
    check("rst_mosi", bus.mosi0_o, 0);
    check("rst_ready", bus.ready_o, 1);
    check("rst_done", bus.done_o, 0);
    check("rst_rx", bus.rx_data_o, 0);
    @(posedge pclk); #1;

    // mode 0, MSB first, baud_div=1
    run_xfer(1'b0, 1'b0, 1'b0, 1, 8'hA5, 8'h3C, -1);
    check("m0_mosi_bits", mon_cap, 8'hA5);
    check("m0_rises", mon_rises, 8);
    check("m0_setup_cycles", mon_setup, 2);
    check("m0_rx", bus.rx_data_o, LB ? 8'hA5 : 8'h3C);
    idle(2);

    // mode 3, LSB first, baud_div=0
    run_xfer(1'b1, 1'b1, 1'b1, 0, 8'h81, 8'h7E, -1);
    check("m3_toggles", mon_toggles, 16);
    check("m3_done_cycles", mon_done, 1);
    check("m3_rx", bus.rx_data_o, 8'h7E ^ (LB ? 8'hFF : 8'h00));
    check("m3_idle_high", bus.sclk_o, 1);
    idle(1);

    // modes 1 and 2 with slave echo
    run_xfer(1'b0, 1'b1, 1'b0, 2, 8'h5A, 8'h5A, -1);
    check("m1_rx", bus.rx_data_o, 8'h5A);
    idle(1);
    run_xfer(1'b1, 1'b0, 1'b0, 1, 8'h5A, 8'h5A, -1);
    check("m2_rx", bus.rx_data_o, 8'h5A);

    // back-to-back with start held
    run_xfer(1'b0, 1'b0, 1'b0, 0, 8'h12, 8'h34, -1);
    run_xfer(1'b0, 1'b0, 1'b1, 0, 8'hE7, 8'h6B, -1);
    check("b2b_rx", bus.rx_data_o, LB ? 8'hE7 : 8'h6B);

    // reset at the 5th toggle, then a clean 0xFF transfer
    run_xfer(1'b1, 1'b0, 1'b0, 1, 8'h3C, 8'h99, 5 * 2);
    @(negedge pclk);
    check("abort_cs_n", bus.cs_n_o, 1);
    check("abort_ready", bus.ready_o, 1);
    check("abort_done", bus.done_o, 0);
    check("abort_sclk", bus.sclk_o, 0);
    check("abort_rx", bus.rx_data_o, 0);
    @(posedge pclk); #1;
    run_xfer(1'b0, 1'b0, 1'b0, 0, 8'hFF, 8'hFF, -1);
    check("post_abort_rx", bus.rx_data_o, 8'hFF);

    // receive path with miso held low
    run_xfer(1'b0, 1'b0, 1'b0, 0, 8'hC3, 8'h00, -1);
    check("lb_rx", bus.rx_data_o, LB ? 8'hC3 : 8'h00);

    for (int k = 0; k < 40; k++) begin
      int gap;
      run_xfer(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
               DW'($urandom), DW'($urandom), -1);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle(gap);
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_master_controller.md
SPI_MASTER_CONTROLLER -- requirements
Module: spi_master_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per transfer.
REQ-002 SHALL have parameter BAUD_DIV_WIDTH, default 8, meaning width of baud_div_i.
REQ-003 SHALL have port pclk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port areset, input, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1, transfer request, sampled only when ready_o=1.
REQ-006 SHALL have port tx_data_i, input, DATA_WIDTH, the word to shift out on mosi0_o.
REQ-007 SHALL have port cpol_i, input, 1, idle clock level.
REQ-008 SHALL have port cpha_i, input, 1, selects the sampling edge: 0=leading, 1=trailing.
REQ-009 SHALL have port lsb_first_i, input, 1, bit order: 0=MSB first, 1=LSB first.
REQ-010 SHALL have port baud_div_i, input, BAUD_DIV_WIDTH, sclk half-period of baud_div_i+1 pclk cycles.
REQ-011 SHALL have port miso0_i, input, 1, serial data from the slave.
REQ-012 SHALL have port sclk_o, output, 1, the SPI clock.
REQ-013 SHALL have port cs_n_o, output, 1, active-low slave select.
REQ-014 SHALL have port mosi0_o, output, 1, serial data to the slave.
REQ-015 SHALL have port ready_o, output, 1, asserted only in IDLE.
REQ-016 SHALL have port done_o, output, 1, one-cycle pulse at transfer end.
REQ-017 SHALL have port rx_data_o, output, DATA_WIDTH, received word, held until the next done_o.

Function
REQ-018 SHALL implement a state machine with states IDLE, SETUP, SHIFT, HOLD and DONE.
REQ-019 In IDLE with start_i=1, SHALL latch tx_data_i, cpol_i, cpha_i, lsb_first_i and baud_div_i, then enter SETUP on the next edge.
REQ-020 SHALL ignore all inputs except areset and miso0_i while not in IDLE; mid-transfer config changes have no effect.
REQ-021 SHALL drive cs_n_o=0 in SETUP, SHIFT and HOLD, and cs_n_o=1 in IDLE and DONE.
REQ-022 SETUP SHALL last exactly one half-period (baud_div+1 cycles); sclk_o equals the latched cpol for the whole of SETUP.
REQ-023 When cpha=0, mosi0_o SHALL present the first bit from SETUP entry onward.
REQ-024 SHIFT SHALL produce exactly 2*DATA_WIDTH sclk_o toggles, each one half-period apart; the first toggle occurs at SHIFT entry.
REQ-025 When cpha=0, SHALL sample miso0_i on odd toggles (leading edges) and update mosi0_o on even toggles, except after the final toggle.
REQ-026 When cpha=1, SHALL update mosi0_o on odd toggles and sample miso0_i on even toggles.
REQ-027 Bit order SHALL follow lsb_first for both mosi0_o and the received word assembly.
REQ-028 After the last toggle, sclk_o SHALL equal cpol; HOLD SHALL last one half-period, then the block enters DONE.
REQ-029 DONE SHALL last one cycle with done_o=1; rx_data_o SHALL update on DONE entry; the next state is IDLE.
REQ-030 Back-to-back transfers: start_i held high SHALL start the next transfer on the cycle after DONE, giving at least one IDLE cycle with cs_n_o=1.
REQ-031 With baud_div=0, the half-period SHALL be one pclk cycle, so sclk runs at pclk/2.
REQ-032 In IDLE, sclk_o SHALL equal the last latched cpol.

Reset
REQ-033 When areset=1 at a pclk edge, SHALL go to IDLE with sclk_o=0, cs_n_o=1, mosi0_o=0, ready_o=1, done_o=0, rx_data_o=0 and latched cpol=0.
REQ-034 Reset mid-transfer SHALL abort the transfer immediately without a done_o pulse; the next start_i after reset is accepted normally.

Configuration
REQ-035 With SPI_MASTER_CTRL_LOOPBACK_EN defined, the receive path SHALL sample internal mosi0_o instead of miso0_i, so rx_data_o equals tx_data; miso0_i is unused.
REQ-036 Without SPI_MASTER_CTRL_LOOPBACK_EN, the receive path SHALL sample miso0_i per REQ-025/REQ-026.

Verification
REQ-037 Mode 0, MSB first, baud_div=1, tx=0xA5, slave returns 0x3C -> mosi bits 1,0,1,0,0,1,0,1; rx_data_o=0x3C; 8 rising sclk edges; SETUP lasts 2 cycles.
REQ-038 Mode 3 (cpol=1, cpha=1), LSB first, baud_div=0, tx=0x81, slave returns 0x7E -> sclk idles high; 16 toggles; rx_data_o=0x7E; done_o high for exactly 1 cycle.
REQ-039 Modes 1 and 2 with tx=0x5A and slave echo -> rx_data_o=0x5A; each miso sample lands on the edge required by REQ-025/REQ-026.
REQ-040 start_i held high across two transfers -> exactly one IDLE cycle with cs_n_o=1 between them; the second word is latched fresh.
REQ-041 areset pulsed at the 5th sclk toggle -> next cycle cs_n_o=1, ready_o=1, no done_o; a new 0xFF transfer completes correctly.
REQ-042 With SPI_MASTER_CTRL_LOOPBACK_EN defined, tx=0xC3 and miso0_i=0 -> rx_data_o=0xC3.
